// File: rtl/cpu_regfile_pkg.sv
// Shared definitions for the multi-port CPU register file.
//   state_e  : sequencer states (CLEAR sweeps the array after reset, RUN is normal operation)
//   ZERO_IDX : hardwired-zero integer register x0
//   FP_BASE  : first float register (f0); f0 is an ordinary writable register
//   addr_width(): address width for a given register count
package cpu_regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned ZERO_IDX = 0;
    localparam int unsigned FP_BASE  = 32;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/cpu_regfile_read_port.sv
// One read port of the register file: zero/bypass/array select plus the
// registered output.
//   i_clock, i_reset : clock, synchronous active-low reset
//   i_run            : 1 when the file is in RUN; output forced to 0 otherwise
//   i_stall          : 1 holds the output register
//   i_addr           : read index for this port
//   i_wr_fire, i_wr_addr, i_wr_data : the write committing at this edge
//   i_rd_data        : array contents at i_addr
//   o_rs             : registered read data
module cpu_regfile_read_port
    import cpu_regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned AW     = 6,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_run,
    input  logic            i_stall,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_wr_fire,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [XLEN-1:0] i_rd_data,
    output logic [XLEN-1:0] o_rs
);

    logic [XLEN-1:0] rs_q, rs_d;

    always_comb begin
        rs_d = rs_q;
        if (!i_run) begin
            rs_d = '0;
        end else if (!i_stall) begin
            if (i_addr == AW'(ZERO_IDX)) begin
                rs_d = '0;
            end else if (BYPASS && i_wr_fire && (i_wr_addr == i_addr)) begin
                // forward the value being written this edge instead of the stale array entry
                rs_d = i_wr_data;
            end else begin
                rs_d = i_rd_data;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            rs_q <= '0;
        end else begin
            rs_q <= rs_d;
        end
    end

    assign o_rs = rs_q;

endmodule

// File: rtl/cpu_register_file_mp.sv
// Parametrised multi-port register file: integer regs 0..31, float regs
// 32..NREGS-1 in one array. After reset an iterative sequencer clears the
// array one entry per cycle (loading STACK_POINTER at SP_INDEX) so the array
// carries no reset and can map to block RAM.
//   i_clock   : clock, rising edge
//   i_reset   : synchronous active-low reset
//   i_stall   : 1 holds all read outputs
//   i_rs_addr : NREAD packed read indices
//   o_rs      : NREAD packed registered read data (1-cycle latency)
//   i_wr_tag  : a tag differing from the last accepted one marks a new write
//   i_wr_addr : write index (writes to index 0 are discarded)
//   i_wr_data : write data
//   o_ready   : 1 once the clear sweep has finished
module cpu_register_file_mp
    import cpu_regfile_pkg::*;
#(
    parameter int unsigned     XLEN          = 32,
    parameter int unsigned     NREGS         = 64,
    parameter int unsigned     NREAD         = 3,
    parameter int unsigned     TAG_W         = 4,
    parameter logic [XLEN-1:0] STACK_POINTER = '0,
    parameter int unsigned     SP_INDEX      = 2,
    parameter bit              BYPASS        = 1'b1,
    localparam int unsigned    AW            = addr_width(NREGS)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic [NREAD*AW-1:0]   i_rs_addr,
    output logic [NREAD*XLEN-1:0] o_rs,
    input  logic [TAG_W-1:0]      i_wr_tag,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic                  o_ready
);

    // One extra bit so the terminal compare never depends on wrap-around.
    localparam int unsigned CW = AW + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               ready_q, ready_d;
    logic [XLEN-1:0]    mem_q [NREGS];

    logic               run;
    logic               wr_fire;
    logic               clr_we;
    logic [XLEN-1:0]    clr_val;

    assign run     = (state_q == RUN);
    assign wr_fire = run && (i_wr_tag != tag_q);
    assign clr_we  = (state_q == CLEAR) && i_reset;
    assign clr_val = (cnt_q == CW'(SP_INDEX)) ? STACK_POINTER : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        // The tag is tracked in both states: during CLEAR this swallows tag
        // changes so nothing stale commits once RUN starts; in RUN it only
        // differs from tag_q when a write fires.
        tag_d   = i_wr_tag;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NREGS - 1)) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            tag_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            ready_q <= ready_d;
        end
    end

    // Array has no reset; the CLEAR sweep initialises it.
    always_ff @(posedge i_clock) begin
        if (clr_we) begin
            mem_q[cnt_q[AW-1:0]] <= clr_val;
        end else if (wr_fire && (i_wr_addr != AW'(ZERO_IDX))) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_port
        logic [AW-1:0] addr_k;
        assign addr_k = i_rs_addr[k*AW +: AW];

        cpu_regfile_read_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .BYPASS (BYPASS)
        ) u_port (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_run     (run),
            .i_stall   (i_stall),
            .i_addr    (addr_k),
            .i_wr_fire (wr_fire),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .i_rd_data (mem_q[addr_k]),
            .o_rs      (o_rs[k*XLEN +: XLEN])
        );
    end

    assign o_ready = ready_q;

endmodule

// File: tb/tb_cpu_register_file_mp.sv
module tb_cpu_register_file_mp;

    localparam logic [31:0] SP_A = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [17:0] rs_addr;
    logic [3:0]  wr_tag;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [95:0] rs_a, rs_b;
    logic        rdy_a, rdy_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // dut_a: bypass on, non-zero stack pointer; dut_b: bypass off, default SP.
    cpu_register_file_mp #(
        .XLEN(32), .NREGS(64), .NREAD(3), .TAG_W(4),
        .STACK_POINTER(SP_A), .SP_INDEX(2), .BYPASS(1'b1)
    ) dut_a (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_rs_addr(rs_addr),
        .o_rs(rs_a), .i_wr_tag(wr_tag), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_ready(rdy_a)
    );

    cpu_register_file_mp #(
        .XLEN(32), .NREGS(64), .NREAD(3), .TAG_W(4),
        .SP_INDEX(2), .BYPASS(1'b0)
    ) dut_b (
        .i_clock(clk), .i_reset(rst), .i_stall(stall), .i_rs_addr(rs_addr),
        .o_rs(rs_b), .i_wr_tag(wr_tag), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .o_ready(rdy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_left: number of clear cycles still to run (0 = running normally).
    bit          m_valid = 1'b0;
    int          m_left [2];
    logic [31:0] m_r    [2][64];
    logic [3:0]  m_tag  [2];
    logic [31:0] m_rs   [2][3];
    bit          m_rdy  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] sp;
            bit          byp;
            bit          fire;
            sp  = (d == 0) ? SP_A : 32'h0;
            byp = (d == 0);
            if (!rst) begin
                m_left[d] = 64;
                m_tag[d]  = '0;
                m_rdy[d]  = 1'b0;
                for (int k = 0; k < 3; k++) m_rs[d][k] = '0;
                if (d == 1) m_valid = 1'b1;
            end else if (m_left[d] > 0) begin
                int idx;
                idx = 64 - m_left[d];
                m_r[d][idx] = (idx == 2) ? sp : 32'h0;
                m_left[d]--;
                if (m_left[d] == 0) m_rdy[d] = 1'b1;
                m_tag[d] = wr_tag;
            end else begin
                fire = (wr_tag != m_tag[d]);
                if (!stall) begin
                    for (int k = 0; k < 3; k++) begin
                        int a;
                        a = int'(rs_addr[k*6 +: 6]);
                        if (a == 0)                                    m_rs[d][k] = '0;
                        else if (byp && fire && int'(wr_addr) == a)    m_rs[d][k] = wr_data;
                        else                                           m_rs[d][k] = m_r[d][a];
                    end
                end
                if (fire) begin
                    m_tag[d] = wr_tag;
                    if (wr_addr != 0) m_r[d][wr_addr] = wr_data;
                end
            end
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("ready_a", {31'b0, rdy_a}, {31'b0, m_rdy[0]});
            check("ready_b", {31'b0, rdy_b}, {31'b0, m_rdy[1]});
            for (int k = 0; k < 3; k++) begin
                check($sformatf("rs_a[%0d]", k), rs_a[k*32 +: 32], m_rs[0][k]);
                check($sformatf("rs_b[%0d]", k), rs_b[k*32 +: 32], m_rs[1][k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [5:0] a);
        rs_addr[k*6 +: 6] = a;
    endtask

    // Literal pin on both DUTs and the model for one port.
    task automatic pin(input string name, input int k, input logic [31:0] ea, input logic [31:0] eb);
        check({name, "_a"}, rs_a[k*32 +: 32], ea);
        check({name, "_b"}, rs_b[k*32 +: 32], eb);
        check({name, "_model"}, m_rs[0][k], ea);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!rdy_a && n < 200);
        check(name, n, 64);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; rs_addr = '0;
        wr_tag = '0; wr_addr = '0; wr_data = '0;
        repeat (3) step();
        check("reset_ready", {31'b0, rdy_a}, 32'h0);
        check("reset_rs0", rs_a[31:0], 32'h0);
        rst = 1'b1;
        wait_ready("clear_len");

        // stack pointer and neighbouring cleared registers
        set_rd(0, 6'd2); set_rd(1, 6'd3); set_rd(2, 6'd63);
        step();
        pin("sp_read", 0, SP_A, 32'h0);
        pin("r3_clear", 1, 32'h0, 32'h0);
        pin("r63_clear", 2, 32'h0, 32'h0);

        // tagged write then read; repeated tag must not write
        wr_tag = 4'd1; wr_addr = 6'd5; wr_data = 32'hDEAD_BEEF;
        step();
        set_rd(0, 6'd5);
        step();
        pin("wr_r5", 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wr_data = 32'h1234;
        step(); step();
        pin("same_tag", 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // x0 hardwired, f0 writable
        wr_tag = 4'd2; wr_addr = 6'd0; wr_data = 32'hFFFF_FFFF;
        step();
        set_rd(0, 6'd0);
        step();
        pin("x0", 0, 32'h0, 32'h0);
        wr_tag = 4'd3; wr_addr = 6'd32; wr_data = 32'h3F80_0000;
        step();
        set_rd(0, 6'd32);
        step();
        pin("f0", 0, 32'h3F80_0000, 32'h3F80_0000);

        // same-cycle bypass on all ports
        wr_tag = 4'd4; wr_addr = 6'd7; wr_data = 32'hA5A5_A5A5;
        set_rd(0, 6'd7); set_rd(1, 6'd7); set_rd(2, 6'd7);
        step();
        for (int k = 0; k < 3; k++) pin($sformatf("bypass%0d", k), k, 32'hA5A5_A5A5, 32'h0);

        // stall hold
        wr_tag = 4'd6; wr_addr = 6'd9; wr_data = 32'h11;
        step();
        set_rd(1, 6'd9);
        step();
        pin("pre_stall", 1, 32'h11, 32'h11);
        stall = 1'b1; set_rd(1, 6'd3);
        wr_tag = 4'd5; wr_addr = 6'd9; wr_data = 32'h22;
        step(); step();
        pin("stalled", 1, 32'h11, 32'h11);
        stall = 1'b0; set_rd(1, 6'd9);
        step();
        pin("unstalled", 1, 32'h22, 32'h22);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            wr_tag  = 4'($urandom_range(0, 3));
            wr_addr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) wr_addr = 6'd0;
            wr_data = $urandom;
            stall   = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < 3; k++)
                set_rd(k, ($urandom_range(0, 1) == 1) ? wr_addr : 6'($urandom_range(0, 63)));
            step();
        end
        stall = 1'b0;

        // reset in the middle of CLEAR restarts the full sweep
        rst = 1'b0; step(); rst = 1'b1;
        repeat (10) step();
        rst = 1'b0; step();
        check("midclear_ready", {31'b0, rdy_a}, 32'h0);
        rst = 1'b1;
        wait_ready("clear_len_restart");

        // reset during RUN wipes r5; tag 0 right after clear does not write
        wr_tag = 4'd9; wr_addr = 6'd5; wr_data = 32'h55;
        step();
        set_rd(0, 6'd5);
        step();
        pin("r5_before_reset", 0, 32'h55, 32'h55);
        wr_tag = 4'd0; wr_addr = 6'd5; wr_data = 32'h77;
        rst = 1'b0; step();
        check("run_reset_ready", {31'b0, rdy_a}, 32'h0);
        rst = 1'b1;
        wait_ready("clear_len_run");
        step();
        pin("r5_after_reset", 0, 32'h0, 32'h0);
        step();
        pin("tag0_nofire", 0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
